// File: rtl/tiny_canvas_pkg.sv
// Shared types for the tiny canvas pixel path.
//  COORD_W / COLOR_W : pixel coordinate and RGB widths
//  pixel_entry_t     : one queued pixel {restore, color, y, x}
package tiny_canvas_pkg;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned COLOR_W = 3;

    typedef struct packed {
        logic               restore;
        logic [COLOR_W-1:0] color;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } pixel_entry_t;

    localparam int unsigned ENTRY_W = $bits(pixel_entry_t);

endpackage

// File: rtl/pixel_fifo_mem.sv
// Pixel FIFO storage: DEPTH x pixel_entry_t register array.
//  clk   : write clock
//  we    : write enable, waddr/wdata written on the rising edge
//  raddr : asynchronous read address, rdata follows it combinationally
module pixel_fifo_mem
    import tiny_canvas_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  pixel_entry_t      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output pixel_entry_t      rdata
);

    pixel_entry_t mem [DEPTH];

    // Storage needs no reset: the top gates the head with head_valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_queue.sv
// Pixel write queue between the packet stage and the I2C readout.
// Merges painted pixels (priority) and undo/redo restore pixels (via a
// one-entry holding register) into a first-word fall-through FIFO and
// counts every lost entry.
//  clk, rst_n                         : clock, async active-low reset
//  pkt_valid/pkt_x/pkt_y/pkt_color    : painted pixel pulse
//  rst_valid/rst_x/rst_y/rst_color    : restore pixel pulse
//  pop                                : consumer took the head entry
//  flush                              : clear FIFO, hold reg, dedup state
//  clr_drop                           : clear overflow and drop_cnt
//  head_valid/head_x/head_y/head_color/head_restore : FWFT head
//  level                              : occupied entries 0..DEPTH
//  overflow / drop_cnt                : sticky loss flag, saturating count
// Build option: define PIXQ_DEDUP_EN to discard a painted pixel equal to
// the last accepted painted pixel.
module pixel_queue
    import tiny_canvas_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned DROP_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_valid,
    input  logic [7:0]         pkt_x,
    input  logic [7:0]         pkt_y,
    input  logic [2:0]         pkt_color,
    input  logic               rst_valid,
    input  logic [7:0]         rst_x,
    input  logic [7:0]         rst_y,
    input  logic [2:0]         rst_color,
    input  logic               pop,
    input  logic               flush,
    input  logic               clr_drop,
    output logic               head_valid,
    output logic [7:0]         head_x,
    output logic [7:0]         head_y,
    output logic [2:0]         head_color,
    output logic               head_restore,
    output logic [ADDR_W:0]    level,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_cnt
);

    pixel_entry_t      pkt_entry, rst_entry, hold_entry, wr_entry, rd_entry;
    logic              hold_valid;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   level_next;
    logic              pkt_dup, pkt_push, wr_req, wr_en, pop_en, full;
    logic              hold_load, hold_clear, rst_drop, full_drop;
    logic [1:0]        drop_inc;
    logic [DROP_W:0]   cnt_base, cnt_sum;
    logic [DROP_W-1:0] cnt_next;

    always_comb begin
        pkt_entry         = '0;
        pkt_entry.restore = 1'b0;
        pkt_entry.color   = pkt_color;
        pkt_entry.y       = pkt_y;
        pkt_entry.x       = pkt_x;
        rst_entry         = '0;
        rst_entry.restore = 1'b1;
        rst_entry.color   = rst_color;
        rst_entry.y       = rst_y;
        rst_entry.x       = rst_x;
    end

    // Arbitration: painted pixel first, then held restore, then a fresh
    // restore written straight through when nothing is waiting.
    always_comb begin
        wr_req     = 1'b0;
        wr_entry   = pkt_entry;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        rst_drop   = 1'b0;
        pkt_push   = pkt_valid & ~pkt_dup;
        if (pkt_push) begin
            wr_req = 1'b1;
            if (rst_valid) begin
                if (hold_valid) rst_drop  = 1'b1;
                else            hold_load = 1'b1;
            end
        end else if (hold_valid) begin
            wr_req   = 1'b1;
            wr_entry = hold_entry;
            if (rst_valid) hold_load  = 1'b1;
            else           hold_clear = 1'b1;
        end else if (rst_valid) begin
            wr_req   = 1'b1;
            wr_entry = rst_entry;
        end
    end

    // Full/empty handling; a pop while full frees the slot for this write.
    always_comb begin
        full       = (level == (ADDR_W+1)'(DEPTH));
        pop_en     = pop & (level != '0) & ~flush;
        wr_en      = wr_req & (~full | pop_en) & ~flush;
        full_drop  = wr_req & full & ~pop_en & ~flush;
        level_next = level + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop_en);
        if (flush) level_next = '0;
        drop_inc   = 2'({1'b0, rst_drop & ~flush}) + 2'({1'b0, full_drop});
        cnt_base   = clr_drop ? '0 : {1'b0, drop_cnt};
        cnt_sum    = cnt_base + (DROP_W+1)'(drop_inc);
        cnt_next   = cnt_sum[DROP_W] ? '1 : cnt_sum[DROP_W-1:0];
    end

    pixel_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Pointers, level and the restore holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_valid <= 1'b0;
            hold_valid <= 1'b0;
            hold_entry <= '0;
        end else begin
            level      <= level_next;
            head_valid <= (level_next != '0);
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                hold_valid <= 1'b0;
            end else begin
                if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
                if (pop_en) rd_ptr <= rd_ptr + 1'b1;
                if (hold_load) begin
                    hold_valid <= 1'b1;
                    hold_entry <= rst_entry;
                end else if (hold_clear) begin
                    hold_valid <= 1'b0;
                end
            end
        end
    end

    // Loss accounting; a drop in the same cycle as clr_drop survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_drop || drop_inc != 2'd0) begin
            overflow <= (drop_inc != 2'd0);
            drop_cnt <= cnt_next;
        end
    end

`ifdef PIXQ_DEDUP_EN
    logic                         last_valid;
    logic [2*COORD_W+COLOR_W-1:0] last_pix;

    assign pkt_dup = last_valid && (last_pix == {pkt_color, pkt_y, pkt_x});

    // Remember the last painted pixel that actually entered the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid <= 1'b0;
            last_pix   <= '0;
        end else if (flush) begin
            last_valid <= 1'b0;
        end else if (pkt_push && wr_en) begin
            last_valid <= 1'b1;
            last_pix   <= {pkt_color, pkt_y, pkt_x};
        end
    end
`else
    assign pkt_dup = 1'b0;
`endif

    // Head reads as zero while empty so reset/flush show a clean bus.
    always_comb begin
        head_x       = head_valid ? rd_entry.x       : '0;
        head_y       = head_valid ? rd_entry.y       : '0;
        head_color   = head_valid ? rd_entry.color   : '0;
        head_restore = head_valid ? rd_entry.restore : 1'b0;
    end

endmodule

// File: tb/tb_pixel_queue.sv
// Self-checking bench for pixel_queue: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_pixel_queue;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DROP_W = 8;
    localparam int          DROP_MAX = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pkt_valid, rst_valid, pop, flush, clr_drop;
    logic [7:0]        pkt_x, pkt_y, rst_x, rst_y;
    logic [2:0]        pkt_color, rst_color;
    logic              head_valid, head_restore;
    logic [7:0]        head_x, head_y;
    logic [2:0]        head_color;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [19:0] mq[$];
    logic        m_hold_v;
    logic [19:0] m_hold;
    logic        m_last_v;
    logic [18:0] m_last;
    logic        m_ov;
    int          m_dc;

    pixel_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_valid(pkt_valid), .pkt_x(pkt_x), .pkt_y(pkt_y), .pkt_color(pkt_color),
        .rst_valid(rst_valid), .rst_x(rst_x), .rst_y(rst_y), .rst_color(rst_color),
        .pop(pop), .flush(flush), .clr_drop(clr_drop),
        .head_valid(head_valid), .head_x(head_x), .head_y(head_y),
        .head_color(head_color), .head_restore(head_restore),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] head_word();
        return 32'({head_restore, head_color, head_y, head_x});
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_hold_v = 1'b0; m_hold = '0;
        m_last_v = 1'b0; m_last = '0;
        m_ov = 1'b0; m_dc = 0;
    endfunction

    // One clock of the queue, straight from the behavioural rules.
    function automatic void model_step(
        input logic pv, input logic [7:0] px, input logic [7:0] py, input logic [2:0] pc,
        input logic rv, input logic [7:0] rx, input logic [7:0] ry, input logic [2:0] rc,
        input logic pp, input logic fl, input logic cl);
        int          drops = 0;
        logic        have_w = 1'b0;
        logic        is_pkt = 1'b0;
        logic [19:0] w = '0;
        logic [19:0] r_ent = {1'b1, rc, ry, rx};
        logic        dup = 1'b0;
        if (fl) begin
            mq.delete();
            m_hold_v = 1'b0;
            m_last_v = 1'b0;
        end else begin
`ifdef PIXQ_DEDUP_EN
            dup = m_last_v && (m_last == {pc, py, px});
`endif
            if (pv && !dup) begin
                have_w = 1'b1; is_pkt = 1'b1; w = {1'b0, pc, py, px};
                if (rv) begin
                    if (m_hold_v) drops++;
                    else begin m_hold_v = 1'b1; m_hold = r_ent; end
                end
            end else if (m_hold_v) begin
                have_w = 1'b1; w = m_hold;
                if (rv) m_hold = r_ent;
                else    m_hold_v = 1'b0;
            end else if (rv) begin
                have_w = 1'b1; w = r_ent;
            end
            if (pp && mq.size() > 0) begin
                if (have_w) mq.push_back(w);
                void'(mq.pop_front());
                if (have_w && is_pkt) begin m_last_v = 1'b1; m_last = w[18:0]; end
            end else if (have_w) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(w);
                    if (is_pkt) begin m_last_v = 1'b1; m_last = w[18:0]; end
                end else begin
                    drops++;
                end
            end
        end
        if (cl) begin
            m_ov = (drops > 0);
            m_dc = drops;
        end else if (drops > 0) begin
            m_ov = 1'b1;
            m_dc = m_dc + drops;
        end
        if (m_dc > DROP_MAX) m_dc = DROP_MAX;
    endfunction

    task automatic check_model();
        check("head_valid", 32'(head_valid), 32'(mq.size() > 0));
        check("level", 32'(level), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ov));
        check("drop_cnt", 32'(drop_cnt), 32'(m_dc));
        check("head", head_word(), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    endtask

    task automatic step(
        input logic pv, input logic [7:0] px, input logic [7:0] py, input logic [2:0] pc,
        input logic rv, input logic [7:0] rx, input logic [7:0] ry, input logic [2:0] rc,
        input logic pp, input logic fl, input logic cl);
        pkt_valid = pv; pkt_x = px; pkt_y = py; pkt_color = pc;
        rst_valid = rv; rst_x = rx; rst_y = ry; rst_color = rc;
        pop = pp; flush = fl; clr_drop = cl;
        model_step(pv, px, py, pc, rv, rx, ry, rc, pp, fl, cl);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_pop();      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_flush();    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic do_clr();      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic pkt(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
        step(1, x, y, c, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pop_pct;
        rst_n = 1'b0;
        pkt_valid = 0; pkt_x = 0; pkt_y = 0; pkt_color = 0;
        rst_valid = 0; rst_x = 0; rst_y = 0; rst_color = 0;
        pop = 0; flush = 0; clr_drop = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_head_valid", 32'(head_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_head", head_word(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single painted pixel, one-cycle latency.
        pkt(8'd5, 8'd9, 3'b101);
        check("t1_head_valid", 32'(head_valid), 32'd1);
        check("t1_head", head_word(), 32'h5_09_05);
        check("t1_level", 32'(level), 32'd1);

        // Overfill by one, then clear the loss counters.
        do_flush();
        for (int i = 0; i < 17; i++) pkt(8'(i), 8'd1, 3'd2);
        check("t2_level", 32'(level), 32'd16);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_drop_cnt", 32'(drop_cnt), 32'd1);
        do_clr();
        check("t2_clr_overflow", 32'(overflow), 32'd0);
        check("t2_clr_drop_cnt", 32'(drop_cnt), 32'd0);

        // Full FIFO: pop and push together keep the level and drop nothing.
        step(1, 8'hAA, 8'hBB, 3'd6, 0, 0, 0, 0, 1, 0, 0);
        check("t4_level", 32'(level), 32'd16);
        check("t4_drop_cnt", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 15; i++) do_pop();
        check("t4_last_head", head_word(), 32'h6_BB_AA);
        check("t4_last_level", 32'(level), 32'd1);

        // Collision: painted pixel first, restore follows from the hold reg.
        do_flush();
        step(1, 8'd1, 8'd1, 3'd1, 1, 8'd2, 8'd2, 3'd2, 0, 0, 0);
        check("t3_level_first", 32'(level), 32'd1);
        idle();
        check("t3_level_drained", 32'(level), 32'd2);
        check("t3_head0", head_word(), 32'h1_01_01);
        do_pop();
        check("t3_head1", head_word(), 32'hA_02_02);

        // Pop on empty is ignored; flush keeps the loss counters.
        do_flush();
        do_pop();
        check("t5_empty_level", 32'(level), 32'd0);
        check("t5_empty_valid", 32'(head_valid), 32'd0);
        for (int i = 0; i < 17; i++) pkt(8'(i + 32), 8'd3, 3'd4);
        for (int i = 0; i < 9; i++) do_pop();
        check("t5_level7", 32'(level), 32'd7);
        do_flush();
        check("t5_flush_level", 32'(level), 32'd0);
        check("t5_flush_valid", 32'(head_valid), 32'd0);
        check("t5_flush_overflow", 32'(overflow), 32'd1);
        check("t5_flush_drop_cnt", 32'(drop_cnt), 32'd1);

        // Repeated identical painted pixel.
        do_clr();
        pkt(8'd4, 8'd4, 3'd7);
        pkt(8'd4, 8'd4, 3'd7);
`ifdef PIXQ_DEDUP_EN
        check("t6_level", 32'(level), 32'd1);
`else
        check("t6_level", 32'(level), 32'd2);
`endif
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);

        // Randomized traffic with varying drain rate.
        pop_pct = 30;
        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 0) pop_pct = int'($urandom_range(10, 90));
            step(($urandom % 3) == 0, 8'($urandom % 4), 8'($urandom % 4), 3'($urandom % 8),
                 ($urandom % 4) == 0, 8'($urandom % 4), 8'($urandom % 4), 3'($urandom % 8),
                 int'($urandom % 100) < pop_pct,
                 ($urandom % 200) == 0, ($urandom % 100) == 0);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
